// File: rtl/match_window_monitor.sv
// -----------------------------------------------------------------------------
// match_window_monitor
//
// Purpose:
//   Consumes the single-cycle match pulse of a serial sequence detector and
//   counts the matches over repeating windows of programmable length. It keeps
//   the count of the last completed window and a saturating lifetime total.
//   A sticky alarm is raised when the matches in one window reach a threshold.
//
// Configuration macro:
//   MATCH_WIN_PEAK_EN - when defined, adds o_peak_cnt, the largest window
//                       count seen since reset or the last clear.
//
// Ports:
//   i_clk        system clock, all state updates on the rising edge
//   i_rst_n      asynchronous reset, active low
//   i_en         monitor enable; low aborts the window and returns to idle
//   i_clr        synchronous clear of counters, alarm and peak
//   i_match      detector output; each high cycle counts as one match
//   i_win_len    window length in clock cycles (0 behaves as 1), sampled at
//                every window start
//   i_thresh     alarm threshold; 0 disables the alarm
//   o_win_cnt    matches so far in the current window
//   o_last_cnt   final count of the last completed window
//   o_total_cnt  saturating lifetime match count
//   o_win_done   one-cycle pulse in the first cycle after a window closes
//   o_alarm      sticky alarm flag
//   o_peak_cnt   (MATCH_WIN_PEAK_EN only) highest closing window count
// -----------------------------------------------------------------------------
module match_window_monitor #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_match,
    input  logic [WIN_W-1:0] i_win_len,
    input  logic [CNT_W-1:0] i_thresh,
    output logic [CNT_W-1:0] o_win_cnt,
    output logic [CNT_W-1:0] o_last_cnt,
    output logic [CNT_W-1:0] o_total_cnt,
    output logic             o_win_done,
`ifdef MATCH_WIN_PEAK_EN
    output logic [CNT_W-1:0] o_peak_cnt,
`endif
    output logic             o_alarm
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_ALARM = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [WIN_W-1:0] LEN_ONE = {{(WIN_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [WIN_W-1:0] r_timer;
    logic [WIN_W-1:0] r_len;
    logic [CNT_W-1:0] r_win_cnt;
    logic [CNT_W-1:0] r_last_cnt;
    logic [CNT_W-1:0] r_total_cnt;
    logic             r_win_done;
    logic             r_alarm;
`ifdef MATCH_WIN_PEAK_EN
    logic [CNT_W-1:0] r_peak_cnt;
    logic [CNT_W-1:0] w_peak_next;
`endif

    logic [WIN_W-1:0] w_len_eff;
    logic [CNT_W:0]   w_win_sum;
    logic [CNT_W:0]   w_total_sum;
    logic [CNT_W-1:0] w_win_next;
    logic [CNT_W-1:0] w_total_next;
    logic             w_win_last;
    logic             w_thresh_hit;

    // A zero window length would never close; treat it as one cycle.
    assign w_len_eff = (i_win_len == '0) ? LEN_ONE : i_win_len;

    // One extra bit catches the carry out; a carry means the counter was
    // already at its maximum, so the result saturates instead of wrapping.
    assign w_win_sum    = {1'b0, r_win_cnt}   + {{CNT_W{1'b0}}, i_match};
    assign w_total_sum  = {1'b0, r_total_cnt} + {{CNT_W{1'b0}}, i_match};
    assign w_win_next   = w_win_sum[CNT_W]   ? CNT_MAX : w_win_sum[CNT_W-1:0];
    assign w_total_next = w_total_sum[CNT_W] ? CNT_MAX : w_total_sum[CNT_W-1:0];

    // r_len is never zero while a window is running.
    assign w_win_last   = (r_timer == (r_len - LEN_ONE));

    // The match arriving this cycle already counts toward the threshold.
    assign w_thresh_hit = (i_thresh != '0) && (w_win_sum >= {1'b0, i_thresh});

`ifdef MATCH_WIN_PEAK_EN
    assign w_peak_next  = (w_win_next > r_peak_cnt) ? w_win_next : r_peak_cnt;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_len       <= '0;
            r_win_cnt   <= '0;
            r_last_cnt  <= '0;
            r_total_cnt <= '0;
            r_win_done  <= 1'b0;
            r_alarm     <= 1'b0;
`ifdef MATCH_WIN_PEAK_EN
            r_peak_cnt  <= '0;
`endif
        end else begin
            r_win_done <= 1'b0;
            if (i_clr) begin
                // Clear dominates: a match this cycle is dropped and a window
                // closing this cycle produces no done pulse.
                r_win_cnt   <= '0;
                r_last_cnt  <= '0;
                r_total_cnt <= '0;
                r_alarm     <= 1'b0;
                r_timer     <= '0;
                r_len       <= w_len_eff;
                r_state     <= i_en ? S_RUN : S_IDLE;
`ifdef MATCH_WIN_PEAK_EN
                r_peak_cnt  <= '0;
`endif
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_en) begin
                            r_state <= S_RUN;
                            r_timer <= '0;
                            r_len   <= w_len_eff;
                        end
                    end

                    S_RUN, S_ALARM: begin
                        if (!i_en) begin
                            // Abort: the partial window is discarded, while
                            // alarm, total and last count are kept.
                            r_state   <= S_IDLE;
                            r_win_cnt <= '0;
                            r_timer   <= '0;
                        end else begin
                            r_total_cnt <= w_total_next;
                            if ((r_state == S_RUN) && w_thresh_hit) begin
                                r_state <= S_ALARM;
                                r_alarm <= 1'b1;
                            end
                            if (w_win_last) begin
                                r_last_cnt <= w_win_next;
                                r_win_cnt  <= '0;
                                r_win_done <= 1'b1;
                                r_timer    <= '0;
                                r_len      <= w_len_eff;
`ifdef MATCH_WIN_PEAK_EN
                                r_peak_cnt <= w_peak_next;
`endif
                            end else begin
                                r_win_cnt <= w_win_next;
                                r_timer   <= r_timer + LEN_ONE;
                            end
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_win_cnt   = r_win_cnt;
    assign o_last_cnt  = r_last_cnt;
    assign o_total_cnt = r_total_cnt;
    assign o_win_done  = r_win_done;
    assign o_alarm     = r_alarm;
`ifdef MATCH_WIN_PEAK_EN
    assign o_peak_cnt  = r_peak_cnt;
`endif

endmodule

// File: tb/tb_match_window_monitor.sv
// -----------------------------------------------------------------------------
// tb_match_window_monitor
//
// Directed bench for match_window_monitor. Two instances share the stimulus:
// dut8 uses the default 8-bit counters, dut3 uses 3-bit counters so that
// saturation can be reached in a few cycles. Inputs change 1 ns after the
// rising edge and outputs are sampled there too, so each tick() advances one
// window cycle and the outputs seen afterwards reflect that edge.
// -----------------------------------------------------------------------------
module tb_match_window_monitor;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic       match;
    logic [7:0] win_len;
    logic [7:0] thresh;
    logic [2:0] thresh3;

    logic [7:0] w8_win_cnt, w8_last_cnt, w8_total_cnt;
    logic       w8_win_done, w8_alarm;
    logic [2:0] w3_win_cnt, w3_last_cnt, w3_total_cnt;
    logic       w3_win_done, w3_alarm;
`ifdef MATCH_WIN_PEAK_EN
    logic [7:0] w8_peak_cnt;
    logic [2:0] w3_peak_cnt;
`endif

    int vectors;
    int miscompares;

    assign thresh3 = thresh[2:0];

    match_window_monitor #(.CNT_W(8), .WIN_W(8)) dut8 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (en),
        .i_clr       (clr),
        .i_match     (match),
        .i_win_len   (win_len),
        .i_thresh    (thresh),
        .o_win_cnt   (w8_win_cnt),
        .o_last_cnt  (w8_last_cnt),
        .o_total_cnt (w8_total_cnt),
        .o_win_done  (w8_win_done),
`ifdef MATCH_WIN_PEAK_EN
        .o_peak_cnt  (w8_peak_cnt),
`endif
        .o_alarm     (w8_alarm)
    );

    match_window_monitor #(.CNT_W(3), .WIN_W(8)) dut3 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (en),
        .i_clr       (clr),
        .i_match     (match),
        .i_win_len   (win_len),
        .i_thresh    (thresh3),
        .o_win_cnt   (w3_win_cnt),
        .o_last_cnt  (w3_last_cnt),
        .o_total_cnt (w3_total_cnt),
        .o_win_done  (w3_win_done),
`ifdef MATCH_WIN_PEAK_EN
        .o_peak_cnt  (w3_peak_cnt),
`endif
        .o_alarm     (w3_alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n   = 1'b0;
        en      = 1'b0;
        clr     = 1'b0;
        match   = 1'b0;
        win_len = 8'd0;
        thresh  = 8'd0;

        // Reset state
        #2;
        chk("rst_win_cnt",   {24'd0, w8_win_cnt},   32'd0);
        chk("rst_last_cnt",  {24'd0, w8_last_cnt},  32'd0);
        chk("rst_total_cnt", {24'd0, w8_total_cnt}, 32'd0);
        chk("rst_win_done",  {31'd0, w8_win_done},  32'd0);
        chk("rst_alarm",     {31'd0, w8_alarm},     32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Match while idle is ignored
        match = 1'b1;
        tick();
        match = 1'b0;
        chk("idle_match_ignored", {24'd0, w8_total_cnt}, 32'd0);

        // Window of 8, matches at cycles 1,4,7
        en = 1'b1; win_len = 8'd8; thresh = 8'd0;
        tick();
        for (int c = 0; c < 8; c++) begin
            match = (c == 1 || c == 4 || c == 7);
            tick();
            if (c == 1) chk("t2_win_cnt_after_c1", {24'd0, w8_win_cnt}, 32'd1);
            if (c == 6) chk("t2_no_done_c7",       {31'd0, w8_win_done}, 32'd0);
        end
        match = 1'b0;
        chk("t2_win_done", {31'd0, w8_win_done},  32'd1);
        chk("t2_last_cnt", {24'd0, w8_last_cnt},  32'd3);
        chk("t2_total",    {24'd0, w8_total_cnt}, 32'd3);
        chk("t2_alarm",    {31'd0, w8_alarm},     32'd0);
        chk("t2_win_cnt",  {24'd0, w8_win_cnt},   32'd0);

        // Async reset mid-window with nonzero counts
        match = 1'b1;
        tick();
        chk("t1_done_pulse_ends", {31'd0, w8_win_done}, 32'd0);
        chk("t1_win_cnt_1",       {24'd0, w8_win_cnt},  32'd1);
        tick();
        chk("t1_win_cnt_2",       {24'd0, w8_win_cnt},  32'd2);
        chk("t1_total_5",         {24'd0, w8_total_cnt}, 32'd5);
        match = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_async_win_cnt", {24'd0, w8_win_cnt},   32'd0);
        chk("t1_async_last",    {24'd0, w8_last_cnt},  32'd0);
        chk("t1_async_total",   {24'd0, w8_total_cnt}, 32'd0);
        en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Window of 10, threshold 2, matches at cycles 2,5
        en = 1'b1; win_len = 8'd10; thresh = 8'd2;
        tick();
        for (int c = 0; c < 10; c++) begin
            match = (c == 2 || c == 5);
            tick();
            if (c == 4) chk("t3_alarm_before", {31'd0, w8_alarm}, 32'd0);
            if (c == 5) chk("t3_alarm_c6",     {31'd0, w8_alarm}, 32'd1);
        end
        match = 1'b0;
        chk("t3_done1",  {31'd0, w8_win_done}, 32'd1);
        chk("t3_last1",  {24'd0, w8_last_cnt}, 32'd2);
        chk("t3_alarm1", {31'd0, w8_alarm},    32'd1);
        repeat (10) tick();
        chk("t3_done2",        {31'd0, w8_win_done},  32'd1);
        chk("t3_last2",        {24'd0, w8_last_cnt},  32'd0);
        chk("t3_alarm_sticky", {31'd0, w8_alarm},     32'd1);
        chk("t3_total",        {24'd0, w8_total_cnt}, 32'd2);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t3_clr_alarm", {31'd0, w8_alarm},     32'd0);
        chk("t3_clr_total", {24'd0, w8_total_cnt}, 32'd0);
        chk("t3_clr_done",  {31'd0, w8_win_done},  32'd0);
        match = 1'b1;
        tick();
        match = 1'b0;
        chk("t3_run_after_clr", {24'd0, w8_win_cnt}, 32'd1);
        chk("t3_alarm_stays_0", {31'd0, w8_alarm},   32'd0);

        // Clear while disabled stays idle
        en = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t5_clr_idle_total", {24'd0, w8_total_cnt}, 32'd0);
        match = 1'b1;
        tick();
        match = 1'b0;
        chk("t5_clr_idle_stays", {24'd0, w8_total_cnt}, 32'd0);

        // Abort a window with en=0 at cycle 3
        en = 1'b1; win_len = 8'd8; thresh = 8'd0;
        tick();
        for (int c = 0; c < 8; c++) begin
            match = (c == 3);
            tick();
        end
        match = 1'b0;
        chk("t5_last_pre",  {24'd0, w8_last_cnt},  32'd1);
        chk("t5_total_pre", {24'd0, w8_total_cnt}, 32'd1);
        match = 1'b1;
        tick();
        tick();
        match = 1'b0;
        tick();
        chk("t5_win_cnt_c3", {24'd0, w8_win_cnt}, 32'd2);
        en = 1'b0;
        tick();
        chk("t5_abort_no_done",  {31'd0, w8_win_done},  32'd0);
        chk("t5_abort_win_cnt",  {24'd0, w8_win_cnt},   32'd0);
        chk("t5_abort_last",     {24'd0, w8_last_cnt},  32'd1);
        chk("t5_abort_total",    {24'd0, w8_total_cnt}, 32'd3);
        en = 1'b1;
        tick();
        repeat (7) tick();
        chk("t5_fresh_no_done_c7", {31'd0, w8_win_done}, 32'd0);
        tick();
        chk("t5_fresh_done", {31'd0, w8_win_done}, 32'd1);
        chk("t5_fresh_last", {24'd0, w8_last_cnt}, 32'd0);

        // Clear together with a match on the last window cycle
        match = 1'b1;
        tick();
        tick();
        match = 1'b0;
        repeat (5) tick();
        chk("t6_win_cnt_c7", {24'd0, w8_win_cnt}, 32'd2);
        clr = 1'b1; match = 1'b1;
        tick();
        clr = 1'b0; match = 1'b0;
        chk("t6_no_done",  {31'd0, w8_win_done},  32'd0);
        chk("t6_win_cnt",  {24'd0, w8_win_cnt},   32'd0);
        chk("t6_last",     {24'd0, w8_last_cnt},  32'd0);
        chk("t6_total",    {24'd0, w8_total_cnt}, 32'd0);
`ifdef MATCH_WIN_PEAK_EN
        chk("t6_peak_clr", {24'd0, w8_peak_cnt},  32'd0);
`endif
        match = 1'b1;
        repeat (3) tick();
        match = 1'b0;
        repeat (5) tick();
        chk("t6_winA_done", {31'd0, w8_win_done}, 32'd1);
        chk("t6_winA_last", {24'd0, w8_last_cnt}, 32'd3);
        match = 1'b1;
        tick();
        match = 1'b0;
        repeat (7) tick();
        chk("t6_winB_done",  {31'd0, w8_win_done},  32'd1);
        chk("t6_winB_last",  {24'd0, w8_last_cnt},  32'd1);
        chk("t6_winB_total", {24'd0, w8_total_cnt}, 32'd4);
`ifdef MATCH_WIN_PEAK_EN
        chk("t6_peak_max", {24'd0, w8_peak_cnt}, 32'd3);
`endif

        // Saturation with 3-bit counters, window of 20, match high 12 cycles
        en = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0; win_len = 8'd20; thresh = 8'd0; en = 1'b1;
        tick();
        match = 1'b1;
        repeat (7) tick();
        chk("t4_w3_win_cnt_7", {29'd0, w3_win_cnt}, 32'd7);
        tick();
        chk("t4_w3_win_cnt_sat8", {29'd0, w3_win_cnt},   32'd7);
        chk("t4_w3_total_sat8",   {29'd0, w3_total_cnt}, 32'd7);
        repeat (4) tick();
        chk("t4_w3_win_cnt_sat12", {29'd0, w3_win_cnt},   32'd7);
        chk("t4_w3_total_sat12",   {29'd0, w3_total_cnt}, 32'd7);
        chk("t4_w8_win_cnt_12",    {24'd0, w8_win_cnt},   32'd12);
        match = 1'b0;
        repeat (7) tick();
        chk("t4_w3_no_done_c19", {31'd0, w3_win_done}, 32'd0);
        tick();
        chk("t4_w3_done",      {31'd0, w3_win_done},  32'd1);
        chk("t4_w3_last_sat",  {29'd0, w3_last_cnt},  32'd7);
        chk("t4_w3_win_cnt_0", {29'd0, w3_win_cnt},   32'd0);
        chk("t4_w3_total_7",   {29'd0, w3_total_cnt}, 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
